iq_mag_acc: RTL and testbench
=============================

IQ_MAG_ACC -- requirements
Module: iq_mag_acc

Interface
REQ-001 The block SHALL have parameter ACC_W, default 40, giving the signed I/Q accumulator width.
REQ-002 The block SHALL have parameter ROOT_W, default 41, giving the result bits produced by the square root, with (2*ACC_W) <= 2*ROOT_W.
REQ-003 The port list SHALL be:
  sys_clk  input  1  system clock, rising edge only; the block has one clock.
  sys_rst  input  1  synchronous, active-high reset.
  ect_data  input  14 signed  demodulation input sample.
  ref_cos  input  14 signed  in-phase reference sample, aligned with ect_data.
  ref_sin  input  14 signed  quadrature reference sample, aligned with ect_data.
  acc_clr  input  1  clears the accumulators and the product pipeline.
  acc_en  input  1  enables accumulation of the current sample.
  add_en  input  1  rising edge starts the magnitude computation.
  sqrt_q  output 48  magnitude floor(sqrt(I^2+Q^2)), zero-extended from ROOT_W.
  sq_valid  output 1  one-cycle pulse when sqrt_q updates.
  busy  output 1  high from the start edge until the sq_valid cycle, inclusive.

Function
REQ-004 Stage 1: every edge SHALL register prod_i = ect_data*ref_cos and prod_q = ect_data*ref_sin (28-bit signed), plus acc_en delayed by one (en_d).
REQ-005 Stage 2: when en_d=1, every edge SHALL update acc_i += sign-extended prod_i and acc_q += sign-extended prod_q (ACC_W signed).
REQ-006 A sample with acc_en sampled high at edge k SHALL appear in acc_i/acc_q after edge k+1.
REQ-007 When acc_clr=1 at an edge, acc_i, acc_q, prod_i, prod_q and en_d SHALL be 0 after that edge; acc_clr SHALL take priority over acc_en.
REQ-008 Accumulator arithmetic SHALL wrap two's-complement, with no saturation; ACC_W=40 covers 1560 samples at full scale (|prod| <= 2^26).
REQ-009 add_en SHALL be registered (add_d); the start condition is add_en=1 and add_d=0 with the FSM in IDLE.
REQ-010 The FSM SHALL have states IDLE, SQ, ROOT and DONE.
REQ-011 IDLE->SQ on the start condition; at that edge acc_i/acc_q SHALL be copied to snapshot registers snap_i/snap_q, using their values before that edge's stage-2 update.
REQ-012 SQ SHALL last one cycle: radicand = snap_i^2 + snap_q^2, unsigned, 2*ROOT_W bits, zero-extended; then SQ->ROOT.
REQ-013 ROOT SHALL run a restoring or non-restoring digit-by-digit square root producing one result bit per cycle, MSB first, for exactly ROOT_W cycles; then ROOT->DONE.
REQ-014 DONE SHALL last one cycle: sqrt_q <= {zeros, root}, sq_valid=1, then DONE->IDLE.
REQ-015 sqrt_q and sq_valid SHALL therefore update on the (ROOT_W+2)th edge after the start edge, which is edge 43 at defaults.
REQ-016 sqrt_q SHALL hold its value between results; sq_valid SHALL be 0 in all states except DONE.
REQ-017 busy SHALL be 1 in SQ, ROOT and DONE, and 0 in IDLE.
REQ-018 A rising add_en while busy=1 SHALL be ignored; it is not queued.
REQ-019 add_en held high SHALL produce only one computation.
REQ-020 acc_clr or acc_en activity while busy SHALL continue to act on the accumulators without affecting the result in progress, which uses snap_i/snap_q.
REQ-021 Result SHALL equal floor(sqrt(I^2+Q^2)) exactly for all I, Q in the ACC_W signed range, including -2^(ACC_W-1).

Reset
REQ-022 sys_rst=1 at an edge SHALL force: FSM=IDLE, sqrt_q=0, sq_valid=0, busy=0, all accumulators, products, snapshots, en_d, add_d and root working registers = 0.
REQ-023 Reset SHALL override all other inputs, including mid-ROOT, where the in-flight result is discarded and no sq_valid is issued.
REQ-024 The first start condition after reset release SHALL be honoured normally.

Verification
REQ-025 Clear, then ect_data=5, ref_cos=3, ref_sin=4 for one acc_en cycle, then start after 3 idle cycles -> sqrt_q=25, sq_valid pulses once, on edge 43 after the start edge.
REQ-026 Same as REQ-025 with ect_data=-5 -> sqrt_q=25; with ref_sin=0 and ect_data=1000, ref_cos=1000 for 100 samples -> sqrt_q=100000000 (0x5F5E100).
REQ-027 I=1, Q=1, giving radicand 2 -> sqrt_q=1; I=Q=0 -> sqrt_q=0 with sq_valid still pulsing.
REQ-028 Full scale: ect_data=-8192, ref_cos=ref_sin=-8192 for 1560 samples -> sqrt_q matches a bench model of floor(sqrt(2*(1560*2^26)^2)), with no accumulator wrap.
REQ-029 Start, then a second add_en pulse at edge 10 and acc_clr at edge 20 -> exactly one sq_valid, and the value is from the snapshot; sys_rst at edge 30 of another run -> no sq_valid, sqrt_q=0, busy=0.

Source files
------------

// File: rtl/iq_mag_acc.sv
// iq_mag_acc: I/Q demodulating accumulator with a bit-serial magnitude
// (floor(sqrt(I^2 + Q^2))) engine started on a rising add_en.
module iq_mag_acc #(
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned ROOT_W = 41
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic signed [13:0] ect_data,
  input  logic signed [13:0] ref_cos,
  input  logic signed [13:0] ref_sin,
  input  logic               acc_clr,
  input  logic               acc_en,
  input  logic               add_en,
  output logic [47:0]        sqrt_q,
  output logic               sq_valid,
  output logic               busy
);

  localparam int unsigned PROD_W = 28;
  localparam int unsigned OUT_W  = 48;
  localparam int unsigned SQ_W   = 2 * ACC_W;
  localparam int unsigned RAD_W  = 2 * ROOT_W;
  localparam int unsigned REM_W  = ROOT_W + 1;
  localparam int unsigned TRY_W  = ROOT_W + 3;
  localparam int unsigned CNT_W  = $clog2(ROOT_W + 1);

  typedef enum logic [1:0] {IDLE, SQ, ROOT, DONE} state_t;

  state_t                    state, state_nxt;
  logic signed [PROD_W-1:0]  prod_i, prod_q;
  logic                      en_d, add_d;
  logic signed [ACC_W-1:0]   acc_i, acc_q;
  logic signed [ACC_W-1:0]   snap_i, snap_q;
  logic [RAD_W-1:0]          rad;
  logic [REM_W-1:0]          rem;
  logic [ROOT_W-1:0]         root;
  logic [CNT_W-1:0]          cnt;

  logic                      start_c;
  logic signed [SQ_W-1:0]    ext_i_c, ext_q_c, sq_i_c, sq_q_c;
  logic [RAD_W-1:0]          rad_c;
  logic [TRY_W-1:0]          try_rem_c, try_sub_c;
  logic                      ge_c;
  logic [REM_W-1:0]          rem_c;
  logic [ROOT_W-1:0]         root_c;

  // Stage 1: register the two demodulation products and the delayed enable
  always_ff @(posedge sys_clk) begin
    if (sys_rst || acc_clr) begin
      prod_i <= '0;
      prod_q <= '0;
      en_d   <= 1'b0;
    end else begin
      prod_i <= PROD_W'(ect_data) * PROD_W'(ref_cos);
      prod_q <= PROD_W'(ect_data) * PROD_W'(ref_sin);
      en_d   <= acc_en;
    end
  end

  // Stage 2: wrapping two's-complement accumulation
  always_ff @(posedge sys_clk) begin
    if (sys_rst || acc_clr) begin
      acc_i <= '0;
      acc_q <= '0;
    end else if (en_d) begin
      acc_i <= acc_i + ACC_W'(prod_i);
      acc_q <= acc_q + ACC_W'(prod_q);
    end
  end

  // Start-edge detector history
  always_ff @(posedge sys_clk) begin
    if (sys_rst) add_d <= 1'b0;
    else         add_d <= add_en;
  end

  // FSM state register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM next state; a rising add_en is only honoured in IDLE
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    case (state)
      IDLE: if (add_en && !add_d) begin
        start_c   = 1'b1;
        state_nxt = SQ;
      end
      SQ:   state_nxt = ROOT;
      ROOT: if (cnt == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Radicand from the snapshot; squares of signed values are non-negative
  always_comb begin
    ext_i_c = SQ_W'(snap_i);
    ext_q_c = SQ_W'(snap_q);
    sq_i_c  = ext_i_c * ext_i_c;
    sq_q_c  = ext_q_c * ext_q_c;
    rad_c   = RAD_W'($unsigned(sq_i_c)) + RAD_W'($unsigned(sq_q_c));
  end

  // One restoring square-root step: bring down two radicand bits, try 4r+1
  always_comb begin
    try_rem_c = {rem, rad[RAD_W-1 -: 2]};
    try_sub_c = TRY_W'({root, 2'b01});
    ge_c      = (try_rem_c >= try_sub_c);
    rem_c     = ge_c ? REM_W'(try_rem_c - try_sub_c) : REM_W'(try_rem_c);
    root_c    = {root[ROOT_W-2:0], ge_c};
  end

  // Snapshot, root datapath and registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      snap_i   <= '0;
      snap_q   <= '0;
      rad      <= '0;
      rem      <= '0;
      root     <= '0;
      cnt      <= '0;
      sqrt_q   <= '0;
      sq_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      sq_valid <= (state == DONE);
      busy     <= (state_nxt != IDLE) || (state == DONE);
      if (start_c) begin
        snap_i <= acc_i;
        snap_q <= acc_q;
      end
      case (state)
        SQ: begin
          rad  <= rad_c;
          rem  <= '0;
          root <= '0;
          cnt  <= CNT_W'(ROOT_W - 1);
        end
        ROOT: begin
          rad  <= rad << 2;
          rem  <= rem_c;
          root <= root_c;
          cnt  <= cnt - CNT_W'(1);
        end
        DONE: sqrt_q <= OUT_W'(root);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iq_mag_acc.sv
// tb_iq_mag_acc: directed checks of accumulation, magnitude, latency and
// start/clear/reset interactions for iq_mag_acc.
module tb_iq_mag_acc;

  logic               sys_clk;
  logic               sys_rst;
  logic signed [13:0] ect_data, ref_cos, ref_sin;
  logic               acc_clr, acc_en, add_en;
  logic [47:0]        sqrt_q;
  logic               sq_valid, busy;

  int checks = 0;
  int errors = 0;

  iq_mag_acc dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .ect_data (ect_data),
    .ref_cos  (ref_cos),
    .ref_sin  (ref_sin),
    .acc_clr  (acc_clr),
    .acc_en   (acc_en),
    .add_en   (add_en),
    .sqrt_q   (sqrt_q),
    .sq_valid (sq_valid),
    .busy     (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp_v);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_acc();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
  endtask

  // Accumulate n identical samples, then let the pipeline drain
  task automatic feed(input int d, input int c, input int s, input int n);
    ect_data = 14'(d);
    ref_cos  = 14'(c);
    ref_sin  = 14'(s);
    acc_en   = 1'b1;
    repeat (n) tick();
    acc_en = 1'b0;
    repeat (3) tick();
  endtask

  // Integer square root by binary search on r*r <= x
  function automatic logic [63:0] isqrt(input logic [127:0] x);
    logic [63:0]  r;
    logic [127:0] t;
    r = '0;
    for (int b = 63; b >= 0; b--) begin
      t = {64'd0, r | (64'd1 << b)};
      if (t * t <= x) r = r | (64'd1 << b);
    end
    return r;
  endfunction

  // Start a computation on edge 0 and watch 60 further edges.
  // re_edge/clr_edge/rst_edge inject events at that edge number (-1 = none).
  task automatic run_mag(input string tag, input logic [63:0] exp_q, input bit hold,
                         input int re_edge, input int clr_edge, input int rst_edge);
    int          first;
    int          pulses;
    logic [47:0] val;
    logic        busy_at_valid;
    first = -1;
    pulses = 0;
    val = '0;
    busy_at_valid = 1'b0;
    add_en = 1'b1;
    tick();
    if (!hold) add_en = 1'b0;
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    for (int n = 1; n <= 60; n++) begin
      if (n == re_edge) add_en = 1'b1;
      if (n == re_edge + 1 && !hold) add_en = 1'b0;
      if (n == clr_edge) acc_clr = 1'b1;
      if (n == clr_edge + 1) acc_clr = 1'b0;
      if (n == rst_edge) sys_rst = 1'b1;
      if (n == rst_edge + 1) sys_rst = 1'b0;
      tick();
      if (n == rst_edge) begin
        check({tag, "_rst_sqrt_q"}, 64'(sqrt_q), 64'd0);
        check({tag, "_rst_busy"}, 64'(busy), 64'd0);
        check({tag, "_rst_valid"}, 64'(sq_valid), 64'd0);
      end
      if (sq_valid) begin
        pulses++;
        if (first < 0) begin
          first = n;
          val = sqrt_q;
          busy_at_valid = busy;
        end
      end
    end
    add_en = 1'b0;
    if (rst_edge > 0) begin
      check({tag, "_pulses"}, 64'(pulses), 64'd0);
      check({tag, "_busy_end"}, 64'(busy), 64'd0);
    end else begin
      check({tag, "_latency"}, 64'(first), 64'd43);
      check({tag, "_value"}, 64'(val), exp_q);
      check({tag, "_pulses"}, 64'(pulses), 64'd1);
      check({tag, "_busy_valid"}, 64'(busy_at_valid), 64'd1);
      check({tag, "_busy_end"}, 64'(busy), 64'd0);
      check({tag, "_hold"}, 64'(sqrt_q), exp_q);
    end
  endtask

  initial begin
    logic [127:0] fs;
    sys_rst  = 1'b1;
    ect_data = '0;
    ref_cos  = '0;
    ref_sin  = '0;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    add_en   = 1'b0;
    tick();
    tick();
    check("reset_sqrt_q", 64'(sqrt_q), 64'd0);
    check("reset_valid", 64'(sq_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    sys_rst = 1'b0;
    tick();

    // I=15, Q=20 -> 25
    clear_acc();
    feed(5, 3, 4, 1);
    run_mag("pos", 64'd25, 1'b0, -1, -1, -1);

    // I=-15, Q=-20 -> 25
    clear_acc();
    feed(-5, 3, 4, 1);
    run_mag("neg", 64'd25, 1'b0, -1, -1, -1);

    // I=100*1e6, Q=0 -> 100000000
    clear_acc();
    feed(1000, 1000, 0, 100);
    run_mag("big", 64'd100000000, 1'b0, -1, -1, -1);

    // I=Q=1 -> floor(sqrt(2)) = 1
    clear_acc();
    feed(1, 1, 1, 1);
    run_mag("one", 64'd1, 1'b0, -1, -1, -1);

    // I=Q=0 -> 0, still a valid pulse
    clear_acc();
    run_mag("zero", 64'd0, 1'b0, -1, -1, -1);

    // Full scale: I=Q=1560*2^26, no wrap
    clear_acc();
    feed(-8192, -8192, -8192, 1560);
    fs = 128'd1560 * (128'd1 << 26);
    run_mag("full", isqrt(2 * fs * fs), 1'b0, -1, -1, -1);

    // Retrigger at edge 10 ignored, clear at edge 20 does not disturb result
    clear_acc();
    feed(5, 3, 4, 1);
    run_mag("retrig", 64'd25, 1'b0, 10, 20, -1);
    // The mid-run clear did empty the accumulators
    run_mag("after_clr", 64'd0, 1'b0, -1, -1, -1);

    // add_en held high gives exactly one computation
    feed(1000, 1000, 0, 1);
    run_mag("held", 64'd1000000, 1'b1, -1, -1, -1);

    // Reset at edge 30 aborts the run
    feed(5, 3, 4, 1);
    run_mag("abort", 64'd0, 1'b0, -1, -1, 30);

    // First start after reset is honoured
    feed(5, 3, 4, 1);
    run_mag("post_rst", 64'd25, 1'b0, -1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
